// File: rtl/scan_tx.sv
// Parallel-to-serial frame transmitter.
// Frame: start bit (1), WIDTH data bits LSB first, parity bit, then a one-cycle
// stop/done slot. HOLD stalls the data and parity phases; all outputs are registered.
module scan_tx #(
   parameter int WIDTH      = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] data,
   output logic             load_ready,
   input  logic             hold,
   output logic             so,
   output logic             svalid,
   output logic             sstart,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] SHIFT  = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             par_q, par_d;
   logic             so_d, svalid_d, sstart_d, done_d, load_ready_d;

   // Next-state logic; output registers are loaded with the values for the
   // cycle that follows, so each output reflects the state being entered.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      par_d    = par_q;
      so_d     = so;
      svalid_d = 1'b0;
      sstart_d = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            so_d = 1'b0;
            if (load_valid && load_ready) begin
               shreg_d  = data;
               par_d    = (^data) ^ ODD_PARITY;
               cnt_d    = '0;
               state_d  = START;
               so_d     = 1'b1;
               svalid_d = 1'b1;
               sstart_d = 1'b1;
            end
         end
         START: begin
            // Hold is deliberately ignored here; the start bit never stretches.
            state_d  = SHIFT;
            so_d     = shreg_q[0];
            svalid_d = 1'b1;
         end
         SHIFT: begin
            if (!hold) begin
               svalid_d = 1'b1;
               if (cnt_q == LAST_BIT) begin
                  state_d = PARITY;
                  so_d    = par_q;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
                  shreg_d = shreg_q >> 1;
                  so_d    = shreg_q[1];
               end
            end
         end
         PARITY: begin
            if (!hold) begin
               state_d = STOP;
               so_d    = 1'b0;
               done_d  = 1'b1;
            end
         end
         STOP: begin
            state_d = IDLE;
            cnt_d   = '0;
            so_d    = 1'b0;
         end
         default: begin
            state_d = IDLE;
            so_d    = 1'b0;
         end
      endcase
      load_ready_d = (state_d == IDLE);
   end

   // State and registered outputs; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         cnt_q      <= '0;
         par_q      <= 1'b0;
         so         <= 1'b0;
         svalid     <= 1'b0;
         sstart     <= 1'b0;
         done       <= 1'b0;
         load_ready <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         par_q      <= par_d;
         so         <= so_d;
         svalid     <= svalid_d;
         sstart     <= sstart_d;
         done       <= done_d;
         load_ready <= load_ready_d;
      end
   end

endmodule

// File: doc/scan_tx.md
SCAN_TX -- requirements
Module: scan_tx

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the payload bits per frame (legal range 2..32).
REQ-002 Parameter ODD_PARITY, default 0, SHALL select even parity (0) or odd parity (1).
REQ-003 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RSTN  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 LOAD_VALID  input  1  SHALL mean a parallel word is offered on DATA.
REQ-006 DATA  input  WIDTH  SHALL be the parallel payload to transmit.
REQ-007 LOAD_READY  output  1  SHALL mean the block accepts a word this cycle.
REQ-008 HOLD  input  1  SHALL be the serial-side stall request.
REQ-009 SO  output  1  SHALL be the serial data out.
REQ-010 SVALID  output  1  SHALL mean SO carries a valid frame bit this cycle.
REQ-011 SSTART  output  1  SHALL mark the start bit of a frame.
REQ-012 DONE  output  1  SHALL be a one-cycle pulse at frame end.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have the states IDLE, START, SHIFT, PARITY and STOP.
REQ-015 A word SHALL be accepted only on a rising edge where LOAD_VALID=1 and LOAD_READY=1.
- On acceptance the block SHALL capture DATA into the shift register.
- On acceptance the block SHALL capture the parity bit P = (^DATA) XOR ODD_PARITY.
- On acceptance the FSM SHALL move IDLE->START.
REQ-016 LOAD_READY SHALL be 1 only in IDLE; while busy, DATA and LOAD_VALID SHALL be ignored.
REQ-017 START SHALL last exactly one cycle with SO=1, SVALID=1, SSTART=1, then move to SHIFT; HOLD SHALL have no effect in START.
REQ-018 SHIFT SHALL output DATA LSB first, one bit per unstalled cycle, with SVALID=1 and SSTART=0.
REQ-019 A bit counter of width clog2(WIDTH+1) SHALL move the FSM SHIFT->PARITY after bit WIDTH-1.
REQ-020 PARITY SHALL output P for one unstalled cycle with SVALID=1, then move to STOP.
REQ-021 STOP SHALL last one cycle with SO=0, SVALID=0 and DONE=1, then move to IDLE.
REQ-022 LOAD_READY SHALL return to 1 on the cycle after STOP.
REQ-023 Back-to-back frames SHALL therefore be separated by exactly one IDLE cycle.
REQ-024 Latency with no stall, acceptance at edge k:
- START visible in cycle k+1;
- data bit i visible in cycle k+2+i;
- P visible in cycle k+2+WIDTH;
- DONE=1 in cycle k+3+WIDTH.
REQ-025 HOLD=1 in SHIFT or PARITY SHALL freeze the state, counter and shift register, drive SVALID=0 and keep SO at its current value; the frame SHALL resume on the first cycle with HOLD=0.
REQ-026 HOLD in IDLE or STOP SHALL have no effect.
REQ-027 In IDLE, SO, SVALID, SSTART and DONE SHALL all be 0.

Reset
REQ-028 While RSTN=0, the block SHALL hold state=IDLE, shift register=0, counter=0, SO=0, SVALID=0, SSTART=0, DONE=0 and LOAD_READY=0.
REQ-029 LOAD_READY SHALL go to 1 on the first rising CLK edge after RSTN deasserts.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, without a DONE pulse.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- WIDTH=8, even parity, DATA=8'hA5 accepted at edge k -> SO for cycles k+1..k+10 = 1,1,0,1,0,0,1,0,1,0; SSTART=1 only in cycle k+1; DONE=1 only in cycle k+11.
- ODD_PARITY=1, DATA=8'h00 -> 8 zero data bits, then P=1.
- DATA=8'hFF with HOLD=1 for 3 cycles during data bit 4 -> SVALID=0 for those 3 cycles, SO held at 1, no bit lost or duplicated, DONE delayed by 3 cycles.
- LOAD_VALID held high with 8'h3C then 8'hC3 -> second acceptance exactly WIDTH+4 cycles after the first; DATA changes mid-frame do not alter SO.
- RSTN pulsed low during data bit 5 -> all outputs 0 immediately, no DONE; LOAD_READY=1 at the first edge after release; the next frame is correct.
- HOLD=1 during START and STOP -> timing identical to the no-stall case.
